// File: rtl/gl_matrix_stack.sv
// gl_matrix_stack: OpenGL-style projection/modelview matrix stacks with identity load,
// push/pop, multiplier write-back, registered row read port and a BRAM row loader.
`default_nettype none

module gl_matrix_stack #(
  parameter int DEPTH    = 4,
  parameter int LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        matrix_mode_in,
  input  logic        push_en,
  input  logic        pop_en,
  input  logic        matrix_load_id_en,
  input  logic        matrix_load_en,
  input  logic [31:0] bram_read_in_0,
  input  logic [31:0] bram_read_in_1,
  input  logic [31:0] bram_read_in_2,
  input  logic [31:0] bram_read_in_3,
  input  logic        wb_en,
  input  logic [1:0]  wb_row,
  input  logic [31:0] wb_data_0,
  input  logic [31:0] wb_data_1,
  input  logic [31:0] wb_data_2,
  input  logic [31:0] wb_data_3,
  input  logic        rd_mode,
  input  logic [1:0]  rd_row,
  output logic [31:0] rd_data_0,
  output logic [31:0] rd_data_1,
  output logic [31:0] rd_data_2,
  output logic [31:0] rd_data_3,
  output logic        busy,
  output logic        done,
  output logic        err_overflow,
  output logic        err_underflow,
  output logic        err_busy,
  output logic [3:0]  depth_mv,
  output logic [3:0]  depth_proj
);

  localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          WCW       = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int          WAIT_INIT = (LOAD_LAT > 1) ? LOAD_LAT - 2 : 0;
  localparam logic [3:0]  DEPTH_L   = 4'(DEPTH);
  localparam logic [31:0] ONE_F     = 32'h3F800000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_ROW0 = 3'd2,
    S_ROW1 = 3'd3,
    S_ROW2 = 3'd4,
    S_ROW3 = 3'd5
  } state_t;

  state_t state, next_state;

  logic [31:0] top_q [2][4][4];
  logic [31:0] stk_q [2][DEPTH][4][4];
  logic [3:0]  sp_q  [2];
  logic        load_mode_q;
  logic [WCW-1:0] wait_cnt;

  logic        do_load, do_id, do_push, do_pop, do_wb;
  logic        set_ovf, set_unf, set_busy, cmd_done;
  logic        row_wr;
  logic [1:0]  row_idx;
  logic [3:0]  sp_sel;
  logic [IW-1:0] push_idx, pop_idx;

  assign busy       = (state != S_IDLE);
  assign sp_sel     = sp_q[matrix_mode_in];
  assign push_idx   = sp_sel[IW-1:0];
  assign pop_idx    = IW'(sp_sel - 4'd1);
  assign depth_proj = sp_q[0];
  assign depth_mv   = sp_q[1];

  // Command arbitration: only the highest-priority asserted command acts.
  always_comb begin
    do_load  = 1'b0;
    do_id    = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_wb    = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    set_busy = 1'b0;
    if (busy) begin
      if (matrix_load_en || matrix_load_id_en || push_en || pop_en) begin
        set_busy = 1'b1;
      end else if (wb_en) begin
        if (matrix_mode_in == load_mode_q) set_busy = 1'b1;
        else                               do_wb    = 1'b1;
      end
    end else if (matrix_load_en) begin
      do_load = 1'b1;
    end else if (matrix_load_id_en) begin
      do_id = 1'b1;
    end else if (push_en && pop_en) begin
      set_ovf = 1'b1;
      set_unf = 1'b1;
    end else if (push_en) begin
      if (sp_sel < DEPTH_L) do_push = 1'b1;
      else                  set_ovf = 1'b1;
    end else if (pop_en) begin
      if (sp_sel != 4'd0) do_pop  = 1'b1;
      else                set_unf = 1'b1;
    end else if (wb_en) begin
      do_wb = 1'b1;
    end
  end

  assign cmd_done = do_id | do_push | do_pop | set_ovf | set_unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    row_wr     = 1'b0;
    row_idx    = 2'd0;
    case (state)
      S_IDLE: if (do_load) next_state = (LOAD_LAT > 1) ? S_WAIT : S_ROW0;
      S_WAIT: if (wait_cnt == '0) next_state = S_ROW0;
      S_ROW0: begin next_state = S_ROW1; row_wr = 1'b1; row_idx = 2'd0; end
      S_ROW1: begin next_state = S_ROW2; row_wr = 1'b1; row_idx = 2'd1; end
      S_ROW2: begin next_state = S_ROW3; row_wr = 1'b1; row_idx = 2'd2; end
      S_ROW3: begin next_state = S_IDLE; row_wr = 1'b1; row_idx = 2'd3; end
      default: next_state = S_IDLE;
    endcase
  end

  // Saved entries carry no reset; they are only read after being written by a push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          stk_q[matrix_mode_in][push_idx][r][c] <= top_q[matrix_mode_in][r][c];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        sp_q[m] <= 4'd0;
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            top_q[m][r][c] <= (r == c) ? ONE_F : 32'h0;
          end
        end
      end
      done          <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_busy      <= 1'b0;
      rd_data_0     <= 32'h0;
      rd_data_1     <= 32'h0;
      rd_data_2     <= 32'h0;
      rd_data_3     <= 32'h0;
      load_mode_q   <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      done          <= cmd_done | (state == S_ROW3);
      err_overflow  <= err_overflow  | set_ovf;
      err_underflow <= err_underflow | set_unf;
      err_busy      <= err_busy      | set_busy;
      rd_data_0     <= top_q[rd_mode][rd_row][0];
      rd_data_1     <= top_q[rd_mode][rd_row][1];
      rd_data_2     <= top_q[rd_mode][rd_row][2];
      rd_data_3     <= top_q[rd_mode][rd_row][3];

      if (do_load) begin
        load_mode_q <= matrix_mode_in;
        wait_cnt    <= WCW'(WAIT_INIT);
      end else if (state == S_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end

      if (do_id) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            top_q[matrix_mode_in][r][c] <= (r == c) ? ONE_F : 32'h0;
          end
        end
      end

      if (do_push) sp_q[matrix_mode_in] <= sp_sel + 4'd1;

      if (do_pop) begin
        sp_q[matrix_mode_in] <= sp_sel - 4'd1;
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            top_q[matrix_mode_in][r][c] <= stk_q[matrix_mode_in][pop_idx][r][c];
          end
        end
      end

      if (do_wb) begin
        top_q[matrix_mode_in][wb_row][0] <= wb_data_0;
        top_q[matrix_mode_in][wb_row][1] <= wb_data_1;
        top_q[matrix_mode_in][wb_row][2] <= wb_data_2;
        top_q[matrix_mode_in][wb_row][3] <= wb_data_3;
      end

      // The loader and a concurrent write-back always target different modes.
      if (row_wr) begin
        top_q[load_mode_q][row_idx][0] <= bram_read_in_0;
        top_q[load_mode_q][row_idx][1] <= bram_read_in_1;
        top_q[load_mode_q][row_idx][2] <= bram_read_in_2;
        top_q[load_mode_q][row_idx][3] <= bram_read_in_3;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gl_matrix_stack.sv
// tb_gl_matrix_stack: directed scoreboard bench for gl_matrix_stack (DEPTH=4, LOAD_LAT=1).
`default_nettype none

module tb_gl_matrix_stack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        matrix_mode_in = 1'b0, push_en = 1'b0, pop_en = 1'b0;
  logic        matrix_load_id_en = 1'b0, matrix_load_en = 1'b0;
  logic [31:0] bram_read_in_0 = '0, bram_read_in_1 = '0, bram_read_in_2 = '0, bram_read_in_3 = '0;
  logic        wb_en = 1'b0;
  logic [1:0]  wb_row = '0;
  logic [31:0] wb_data_0 = '0, wb_data_1 = '0, wb_data_2 = '0, wb_data_3 = '0;
  logic        rd_mode = 1'b0;
  logic [1:0]  rd_row = '0;
  logic [31:0] rd_data_0, rd_data_1, rd_data_2, rd_data_3;
  logic        busy, done, err_overflow, err_underflow, err_busy;
  logic [3:0]  depth_mv, depth_proj;

  gl_matrix_stack #(.DEPTH(4), .LOAD_LAT(1)) dut (
    .clk(clk), .rst(rst), .matrix_mode_in(matrix_mode_in),
    .push_en(push_en), .pop_en(pop_en),
    .matrix_load_id_en(matrix_load_id_en), .matrix_load_en(matrix_load_en),
    .bram_read_in_0(bram_read_in_0), .bram_read_in_1(bram_read_in_1),
    .bram_read_in_2(bram_read_in_2), .bram_read_in_3(bram_read_in_3),
    .wb_en(wb_en), .wb_row(wb_row),
    .wb_data_0(wb_data_0), .wb_data_1(wb_data_1), .wb_data_2(wb_data_2), .wb_data_3(wb_data_3),
    .rd_mode(rd_mode), .rd_row(rd_row),
    .rd_data_0(rd_data_0), .rd_data_1(rd_data_1), .rd_data_2(rd_data_2), .rd_data_3(rd_data_3),
    .busy(busy), .done(done), .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_busy(err_busy), .depth_mv(depth_mv), .depth_proj(depth_proj)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } item_t;

  item_t       sb[$];
  int          n_vec = 0;
  int          n_bad = 0;

  logic [31:0] mtop [2][4][4];
  logic [31:0] mstk [2][4][4][4];
  int          msp  [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] exp);
    item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic observe(input logic [31:0] obs);
    item_t it;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty observed %h required an expectation", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        n_bad++;
        $error("FAIL %s observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      msp[m] = 0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          mtop[m][r][c] = (r == c) ? 32'h3F800000 : 32'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic read_row(input logic m, input logic [1:0] r);
    rd_mode = m;
    rd_row  = r;
    for (int c = 0; c < 4; c++) expect_v($sformatf("rd_m%0d_r%0d_c%0d", m, r, c), mtop[m][r][c]);
    tick();
    observe(rd_data_0); observe(rd_data_1); observe(rd_data_2); observe(rd_data_3);
  endtask

  task automatic wb(input logic m, input logic [1:0] r, input logic [31:0] d0, input logic [31:0] d1,
                    input logic [31:0] d2, input logic [31:0] d3);
    matrix_mode_in = m; wb_row = r; wb_en = 1'b1;
    wb_data_0 = d0; wb_data_1 = d1; wb_data_2 = d2; wb_data_3 = d3;
    mtop[m][r][0] = d0; mtop[m][r][1] = d1; mtop[m][r][2] = d2; mtop[m][r][3] = d3;
    expect_v("wb_no_done", 32'd0);
    tick();
    wb_en = 1'b0;
    observe({31'd0, done});
  endtask

  task automatic push_cmd(input logic m);
    if (msp[m] < 4) begin
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) mstk[m][msp[m]][r][c] = mtop[m][r][c];
      msp[m]++;
    end
    matrix_mode_in = m; push_en = 1'b1;
    expect_v("push_done", 32'd1);
    expect_v("push_depth", 32'(msp[m]));
    tick();
    push_en = 1'b0;
    observe({31'd0, done});
    observe(m ? {28'd0, depth_mv} : {28'd0, depth_proj});
  endtask

  task automatic pop_cmd(input logic m);
    if (msp[m] > 0) begin
      msp[m]--;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) mtop[m][r][c] = mstk[m][msp[m]][r][c];
    end
    matrix_mode_in = m; pop_en = 1'b1;
    expect_v("pop_done", 32'd1);
    expect_v("pop_depth", 32'(msp[m]));
    tick();
    pop_en = 1'b0;
    observe({31'd0, done});
    observe(m ? {28'd0, depth_mv} : {28'd0, depth_proj});
  endtask

  function automatic logic [31:0] float_of(input int n);
    case (n)
      1:  return 32'h3F800000;
      2:  return 32'h40000000;
      3:  return 32'h40400000;
      4:  return 32'h40800000;
      6:  return 32'h40C00000;
      8:  return 32'h41000000;
      9:  return 32'h41100000;
      12: return 32'h41400000;
      16: return 32'h41800000;
      default: return 32'hFFFFFFFF;
    endcase
  endfunction

  function automatic logic [31:0] bram_val(input bit gen, input int k, input int c);
    if (gen) return 32'h40000000 + 32'(k * 4 + c);
    return float_of((k + 1) * (c + 1));
  endfunction

  // Full load; with interfere set, a push and two write-backs are issued while busy.
  task automatic load_seq(input logic m, input bit gen, input bit interfere);
    matrix_mode_in = m; matrix_load_en = 1'b1;
    tick();
    matrix_load_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bram_read_in_0 = bram_val(gen, k, 0); bram_read_in_1 = bram_val(gen, k, 1);
      bram_read_in_2 = bram_val(gen, k, 2); bram_read_in_3 = bram_val(gen, k, 3);
      for (int c = 0; c < 4; c++) mtop[m][k][c] = bram_val(gen, k, c);
      if (interfere && k == 0) begin
        matrix_mode_in = m; push_en = 1'b1;
      end
      if (interfere && k == 1) begin
        matrix_mode_in = ~m; wb_en = 1'b1; wb_row = 2'd3;
        wb_data_0 = 32'hD0000000; wb_data_1 = 32'hD0000001;
        wb_data_2 = 32'hD0000002; wb_data_3 = 32'hD0000003;
        mtop[~m][3][0] = 32'hD0000000; mtop[~m][3][1] = 32'hD0000001;
        mtop[~m][3][2] = 32'hD0000002; mtop[~m][3][3] = 32'hD0000003;
      end
      if (interfere && k == 2) begin
        matrix_mode_in = m; wb_en = 1'b1; wb_row = 2'd0;
        wb_data_0 = 32'hEEEE0000; wb_data_1 = 32'hEEEE0000;
        wb_data_2 = 32'hEEEE0000; wb_data_3 = 32'hEEEE0000;
      end
      expect_v($sformatf("load_busy_c%0d", k + 1), 32'd1);
      expect_v($sformatf("load_nodone_c%0d", k + 1), 32'd0);
      observe({31'd0, busy});
      observe({31'd0, done});
      tick();
      push_en = 1'b0; wb_en = 1'b0;
    end
    expect_v("load_busy_end", 32'd0);
    expect_v("load_done_c5", 32'd1);
    expect_v("load_err_busy", interfere ? 32'd1 : 32'd0);
    observe({31'd0, busy});
    observe({31'd0, done});
    observe({31'd0, err_busy});
    tick();
    expect_v("load_done_single", 32'd0);
    observe({31'd0, done});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1);
  end

  initial begin
    model_reset();
    tick();
    tick();
    // Reset state, held in reset.
    expect_v("rst_busy", 32'd0);      observe({31'd0, busy});
    expect_v("rst_done", 32'd0);      observe({31'd0, done});
    expect_v("rst_errs", 32'd0);      observe({29'd0, err_overflow, err_underflow, err_busy});
    expect_v("rst_depth_mv", 32'd0);  observe({28'd0, depth_mv});
    expect_v("rst_depth_pj", 32'd0);  observe({28'd0, depth_proj});
    expect_v("rst_rd_data", 32'd0);   observe(rd_data_0 | rd_data_1 | rd_data_2 | rd_data_3);
    rst = 1'b0;
    tick();
    for (int r = 0; r < 4; r++) read_row(1'b1, 2'(r));
    read_row(1'b0, 2'd0);

    // BRAM load into modelview, then stack fill to overflow and LIFO pops.
    load_seq(1'b1, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++) read_row(1'b1, 2'(r));
    read_row(1'b0, 2'd1);
    for (int i = 0; i < 4; i++) begin
      wb(1'b1, 2'd0, 32'hB0000000 + 32'(i), 32'hB0000010 + 32'(i),
         32'hB0000020 + 32'(i), 32'hB0000030 + 32'(i));
      push_cmd(1'b1);
    end
    push_cmd(1'b1);
    expect_v("ovf_flag", 32'd1);  observe({31'd0, err_overflow});
    expect_v("ovf_no_unf", 32'd0); observe({31'd0, err_underflow});
    read_row(1'b1, 2'd0);
    read_row(1'b1, 2'd1);
    wb(1'b1, 2'd0, 32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003);
    pop_cmd(1'b1);
    read_row(1'b1, 2'd0);
    pop_cmd(1'b1);
    read_row(1'b1, 2'd0);

    // Projection: push, load identity, pop restores, extra pop underflows.
    do_reset();
    for (int r = 0; r < 4; r++)
      wb(1'b0, 2'(r), 32'hA0000000 + 32'(r * 16), 32'hA0000001 + 32'(r * 16),
         32'hA0000002 + 32'(r * 16), 32'hA0000003 + 32'(r * 16));
    push_cmd(1'b0);
    matrix_mode_in = 1'b0; matrix_load_id_en = 1'b1;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) mtop[0][r][c] = (r == c) ? 32'h3F800000 : 32'h0;
    expect_v("load_id_done", 32'd1);
    expect_v("load_id_depth", 32'd1);
    tick();
    matrix_load_id_en = 1'b0;
    observe({31'd0, done});
    observe({28'd0, depth_proj});
    read_row(1'b0, 2'd2);
    pop_cmd(1'b0);
    for (int r = 0; r < 4; r++) read_row(1'b0, 2'(r));
    pop_cmd(1'b0);
    expect_v("unf_flag", 32'd1);  observe({31'd0, err_underflow});
    expect_v("unf_no_ovf", 32'd0); observe({31'd0, err_overflow});

    // Simultaneous push and pop.
    do_reset();
    matrix_mode_in = 1'b1; push_en = 1'b1; pop_en = 1'b1;
    expect_v("pp_errs", 32'b110);
    expect_v("pp_depth", 32'd0);
    tick();
    push_en = 1'b0; pop_en = 1'b0;
    observe({29'd0, err_overflow, err_underflow, err_busy});
    observe({28'd0, depth_mv});
    read_row(1'b1, 2'd0);

    // Commands during a load: ignored with err_busy; write-back to the other mode proceeds.
    do_reset();
    load_seq(1'b1, 1'b1, 1'b1);
    expect_v("busy_push_depth", 32'd0); observe({28'd0, depth_mv});
    expect_v("busy_no_ovf", 32'd0);     observe({31'd0, err_overflow});
    for (int r = 0; r < 4; r++) read_row(1'b1, 2'(r));
    read_row(1'b0, 2'd3);

    // Reset during ROW1 aborts the load.
    do_reset();
    matrix_mode_in = 1'b1; matrix_load_en = 1'b1;
    tick();
    matrix_load_en = 1'b0;
    bram_read_in_0 = 32'h12345678; bram_read_in_1 = 32'h12345678;
    bram_read_in_2 = 32'h12345678; bram_read_in_3 = 32'h12345678;
    tick();
    expect_v("abort_pre_busy", 32'd1); observe({31'd0, busy});
    rst = 1'b1;
    #1;
    expect_v("abort_busy", 32'd0); observe({31'd0, busy});
    expect_v("abort_done", 32'd0); observe({31'd0, done});
    model_reset();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      expect_v($sformatf("abort_no_done_%0d", i), 32'd0);
      tick();
      observe({31'd0, done | busy});
    end
    for (int r = 0; r < 4; r++) read_row(1'b1, 2'(r));

    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_leftover observed %0d required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
